// File: rtl/signed_sub_with_overflow_pipelined_if.sv
`default_nettype none
// ============================================================================
// Module   : signed_sub_with_overflow_pipelined_if
// Brief    : Upstream/downstream valid-ready bundle for the pipelined subtractor.
// Revision : 1.0
// ============================================================================
interface signed_sub_with_overflow_pipelined_if #(
    parameter int WIDTH = 4
);
    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             down_valid;
    logic             down_ready;
    logic [WIDTH-1:0] diff;
    logic             overflow;

    // Producer of operands and consumer of results.
    modport master (
        output up_valid,
        input  up_ready,
        output a,
        output b,
        input  down_valid,
        output down_ready,
        input  diff,
        input  overflow
    );

    // The subtractor itself.
    modport slave (
        input  up_valid,
        output up_ready,
        input  a,
        input  b,
        output down_valid,
        input  down_ready,
        output diff,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/signed_sub_with_overflow_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : signed_sub_with_overflow_pipelined
// Brief    : Two-stage valid/ready pipelined signed a-b with overflow flag and
//            optional saturation.
// Revision : 1.0
// ============================================================================
module signed_sub_with_overflow_pipelined #(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0
) (
    input  wire logic                                 clk,
    input  wire logic                                 rst,
    signed_sub_with_overflow_pipelined_if.slave       bus
);
    localparam int               c_msb  = WIDTH - 1;
    localparam logic [WIDTH-1:0] c_smin = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_smax = {1'b0, {(WIDTH-1){1'b1}}};

    // Stage 1: operand registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    // Stage 2: result registers
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             ovf_q, ovf_d;

    logic             w_s1_free;
    logic             w_s2_free;
    logic [WIDTH-1:0] w_raw;
    logic             w_ovf;
    logic [WIDTH-1:0] w_result;

    assign w_s2_free = !s2_valid_q || bus.down_ready;
    assign w_s1_free = !s1_valid_q || w_s2_free;

    assign w_raw = a_q - b_q;
    // Overflow only possible when operand signs differ; it shows as the
    // result sign disagreeing with the minuend.
    assign w_ovf = (a_q[c_msb] != b_q[c_msb]) && (w_raw[c_msb] != a_q[c_msb]);

    generate
        if (SATURATE != 0) begin : g_sat
            assign w_result = w_ovf ? (a_q[c_msb] ? c_smin : c_smax) : w_raw;
        end else begin : g_wrap
            assign w_result = w_raw;
        end
    endgenerate

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
        ovf_d      = ovf_q;

        if (w_s1_free) begin
            s1_valid_d = bus.up_valid;
            if (bus.up_valid) begin
                a_d = bus.a;
                b_d = bus.b;
            end
        end

        if (w_s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                diff_d = w_result;
                ovf_d  = w_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            s2_valid_q <= s2_valid_d;
            diff_q     <= diff_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.up_ready   = w_s1_free;
    assign bus.down_valid = s2_valid_q;
    assign bus.diff       = diff_q;
    assign bus.overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_signed_sub_with_overflow_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_signed_sub_with_overflow_pipelined
// Brief    : Directed self-checking bench; wrap and saturate instances side by side.
// Revision : 1.0
// ============================================================================
module tb_signed_sub_with_overflow_pipelined;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    signed_sub_with_overflow_pipelined_if #(.WIDTH(4)) bus0 ();
    signed_sub_with_overflow_pipelined_if #(.WIDTH(4)) bus1 ();

    signed_sub_with_overflow_pipelined #(.WIDTH(4), .SATURATE(0)) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    signed_sub_with_overflow_pipelined #(.WIDTH(4), .SATURATE(1)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Hand-computed vectors: a, b, wrapped diff, overflow, saturated diff
    logic [3:0] va  [8] = '{4'h3, 4'hC, 4'hD, 4'h0, 4'hF, 4'h8, 4'h7, 4'h2};
    logic [3:0] vb  [8] = '{4'hB, 4'h7, 4'hB, 4'h8, 4'h8, 4'h8, 4'hF, 4'h1};
    logic [3:0] vd0 [8] = '{4'h8, 4'h5, 4'h2, 4'h8, 4'h7, 4'h0, 4'h8, 4'h1};
    logic       vo  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] vd1 [8] = '{4'h7, 4'h8, 4'h2, 4'h7, 4'h7, 4'h0, 4'h7, 4'h1};

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int k);
        bus0.up_valid = v; bus1.up_valid = v;
        bus0.a = va[k];    bus1.a = va[k];
        bus0.b = vb[k];    bus1.b = vb[k];
    endtask

    task automatic set_dready(input logic r);
        bus0.down_ready = r;
        bus1.down_ready = r;
    endtask

    task automatic check_result(input string tag, input int k);
        check_eq({tag, "_dv0"},  {7'd0, bus0.down_valid}, 8'd1);
        check_eq({tag, "_d0"},   {4'd0, bus0.diff},       {4'd0, vd0[k]});
        check_eq({tag, "_o0"},   {7'd0, bus0.overflow},   {7'd0, vo[k]});
        check_eq({tag, "_dv1"},  {7'd0, bus1.down_valid}, 8'd1);
        check_eq({tag, "_d1"},   {4'd0, bus1.diff},       {4'd0, vd1[k]});
        check_eq({tag, "_o1"},   {7'd0, bus1.overflow},   {7'd0, vo[k]});
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_dv0"}, {7'd0, bus0.down_valid}, 8'd0);
        check_eq({tag, "_dv1"}, {7'd0, bus1.down_valid}, 8'd0);
    endtask

    task automatic check_cleared(input string tag);
        check_idle(tag);
        check_eq({tag, "_d0"},  {4'd0, bus0.diff},       8'd0);
        check_eq({tag, "_o0"},  {7'd0, bus0.overflow},   8'd0);
        check_eq({tag, "_ur0"}, {7'd0, bus0.up_ready},   8'd1);
        check_eq({tag, "_d1"},  {4'd0, bus1.diff},       8'd0);
        check_eq({tag, "_o1"},  {7'd0, bus1.overflow},   8'd0);
        check_eq({tag, "_ur1"}, {7'd0, bus1.up_ready},   8'd1);
    endtask

    initial begin
        drive(1'b0, 0);
        set_dready(1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_cleared("reset");

        // Isolated vectors: accepted at the next posedge, visible two edges later
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1'b1, k);
            check_eq($sformatf("single%0d_ur", k), {7'd0, bus0.up_ready}, 8'd1);
            @(negedge clk);
            drive(1'b0, k);
            check_idle($sformatf("single%0d_lat1", k));
            @(negedge clk);
            check_result($sformatf("single%0d", k), k);
        end
        @(negedge clk);
        check_idle("drain");

        // Back-to-back stream, one result per cycle in order
        for (int c = 0; c < 10; c++) begin
            if (c >= 2) check_result($sformatf("stream%0d", c - 2), c - 2);
            else        check_idle($sformatf("stream_fill%0d", c));
            if (c < 8) begin
                check_eq($sformatf("stream_ur%0d", c), {7'd0, bus0.up_ready}, 8'd1);
                drive(1'b1, c);
            end else begin
                drive(1'b0, 0);
            end
            @(negedge clk);
        end
        check_idle("stream_end");

        // Backpressure: down_ready low for four edges, two pairs accepted
        set_dready(1'b0);
        drive(1'b1, 0);
        @(negedge clk);
        check_eq("bp_ur_after1", {7'd0, bus0.up_ready}, 8'd1);
        drive(1'b1, 1);
        @(negedge clk);
        drive(1'b1, 2);
        for (int c = 0; c < 3; c++) begin
            check_eq($sformatf("bp_ur0_%0d", c), {7'd0, bus0.up_ready}, 8'd0);
            check_eq($sformatf("bp_ur1_%0d", c), {7'd0, bus1.up_ready}, 8'd0);
            check_result($sformatf("bp_hold%0d", c), 0);
            if (c < 2) @(negedge clk);
        end
        set_dready(1'b1);
        #1;
        check_eq("bp_release_ur", {7'd0, bus0.up_ready}, 8'd1);
        @(negedge clk);
        drive(1'b0, 0);
        check_result("bp_out1", 1);
        @(negedge clk);
        check_result("bp_out2", 2);
        @(negedge clk);
        check_idle("bp_end");

        // Reset with both stages occupied
        set_dready(1'b0);
        drive(1'b1, 3);
        @(negedge clk);
        drive(1'b1, 4);
        @(negedge clk);
        check_eq("mid_full_ur", {7'd0, bus0.up_ready}, 8'd0);
        rst = 1'b1;
        drive(1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        check_cleared("mid_rst");
        set_dready(1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle($sformatf("post_rst%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
